// File: rtl/salsa_pipe_mt.sv
// Multi-thread Salsa20/R core for scrypt BlockMix: DR double-rounds of registered quarter-steps,
// items recirculate until all rounds are done, then a registered feed-forward add emits Bo.
module salsa_pipe_mt #(
    parameter int ROUNDS = 8,
    parameter int DR     = 1,
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [TAG_W-1:0]              in_tag,
    input  logic [511:0]                  in_b,
    input  logic [511:0]                  in_bx,
    output logic                          out_valid,
    output logic [TAG_W-1:0]              out_tag,
    output logic [511:0]                  out_bo,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [$clog2(8*DR+1)-1:0]     occupancy,
    output logic                          busy
);
    localparam int L     = 8 * DR;
    localparam int P     = ROUNDS / (2 * DR);
    localparam int PC_W  = (P > 1) ? $clog2(P) : 1;
    localparam int OCC_W = $clog2(L + 1);

    function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] n);
        return (v << n) | (v >> (6'd32 - {1'b0, n}));
    endfunction

    // Stage k of a double-round updates four independent words: x[t] ^= rotl(x[a] + x[b], rot).
    function automatic logic [511:0] quarter_step(input logic [511:0] s, input logic [2:0] k);
        logic [15:0]  tgt;
        logic [15:0]  src_a;
        logic [15:0]  src_b;
        logic [4:0]   rot;
        logic [3:0]   t;
        logic [3:0]   a;
        logic [3:0]   b;
        logic [511:0] r;
        tgt   = 16'h0000;
        src_a = 16'h0000;
        src_b = 16'h0000;
        rot   = 5'd7;
        case (k)
            3'd0: begin tgt = {4'd3, 4'd14, 4'd9, 4'd4};   src_a = {4'd15, 4'd10, 4'd5, 4'd0};  src_b = {4'd11, 4'd6, 4'd1, 4'd12};  rot = 5'd7;  end
            3'd1: begin tgt = {4'd7, 4'd2, 4'd13, 4'd8};   src_a = {4'd3, 4'd14, 4'd9, 4'd4};   src_b = {4'd15, 4'd10, 4'd5, 4'd0};  rot = 5'd9;  end
            3'd2: begin tgt = {4'd11, 4'd6, 4'd1, 4'd12};  src_a = {4'd7, 4'd2, 4'd13, 4'd8};   src_b = {4'd3, 4'd14, 4'd9, 4'd4};   rot = 5'd13; end
            3'd3: begin tgt = {4'd15, 4'd10, 4'd5, 4'd0};  src_a = {4'd11, 4'd6, 4'd1, 4'd12};  src_b = {4'd7, 4'd2, 4'd13, 4'd8};   rot = 5'd18; end
            3'd4: begin tgt = {4'd12, 4'd11, 4'd6, 4'd1};  src_a = {4'd15, 4'd10, 4'd5, 4'd0};  src_b = {4'd14, 4'd9, 4'd4, 4'd3};   rot = 5'd7;  end
            3'd5: begin tgt = {4'd13, 4'd8, 4'd7, 4'd2};   src_a = {4'd12, 4'd11, 4'd6, 4'd1};  src_b = {4'd15, 4'd10, 4'd5, 4'd0};  rot = 5'd9;  end
            3'd6: begin tgt = {4'd14, 4'd9, 4'd4, 4'd3};   src_a = {4'd13, 4'd8, 4'd7, 4'd2};   src_b = {4'd12, 4'd11, 4'd6, 4'd1};  rot = 5'd13; end
            3'd7: begin tgt = {4'd15, 4'd10, 4'd5, 4'd0};  src_a = {4'd14, 4'd9, 4'd4, 4'd3};   src_b = {4'd13, 4'd8, 4'd7, 4'd2};   rot = 5'd18; end
            default: begin tgt = 16'h0000; src_a = 16'h0000; src_b = 16'h0000; rot = 5'd7; end
        endcase
        r = s;
        for (int j = 0; j < 4; j++) begin
            t = tgt[4*j +: 4];
            a = src_a[4*j +: 4];
            b = src_b[4*j +: 4];
            r[{t, 5'd0} +: 32] = s[{t, 5'd0} +: 32] ^ rotl32(s[{a, 5'd0} +: 32] + s[{b, 5'd0} +: 32], rot);
        end
        return r;
    endfunction

    function automatic logic [511:0] add_words(input logic [511:0] x, input logic [511:0] y);
        logic [511:0] r;
        r = 512'd0;
        for (int j = 0; j < 16; j++) begin
            r[32*j +: 32] = x[32*j +: 32] + y[32*j +: 32];
        end
        return r;
    endfunction

    logic [511:0]       st_q   [L];
    logic [511:0]       xx_q   [L];
    logic [TAG_W-1:0]   tag_q  [L];
    logic [PC_W-1:0]    pass_q [L];
    logic               vld_q  [L];
    logic [511:0]       st_d   [L];
    logic [511:0]       xx_d   [L];
    logic [TAG_W-1:0]   tag_d  [L];
    logic [PC_W-1:0]    pass_d [L];
    logic               vld_d  [L];

    logic               recirc_s;
    logic               done_s;
    logic               ready_s;
    logic               accept_s;
    logic [511:0]       sum_s;
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;
    logic               out_valid_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic [511:0]       out_bo_q;
    logic [ADDR_W-1:0]  out_addr_q;

    // Entry mux: a recirculating item owns stage 0, otherwise the slot admits new input or a bubble.
    always_comb begin
        recirc_s = vld_q[L-1] && (pass_q[L-1] != PC_W'(P - 1));
        done_s   = vld_q[L-1] && (pass_q[L-1] == PC_W'(P - 1));
        ready_s  = reset_n && !recirc_s;
        accept_s = ready_s && in_valid;
        sum_s    = add_words(xx_q[L-1], st_q[L-1]);
        if (recirc_s) begin
            st_d[0]   = st_q[L-1];
            xx_d[0]   = xx_q[L-1];
            tag_d[0]  = tag_q[L-1];
            pass_d[0] = pass_q[L-1] + PC_W'(1);
            vld_d[0]  = 1'b1;
        end else begin
            st_d[0]   = in_b ^ in_bx;
            xx_d[0]   = in_b ^ in_bx;
            tag_d[0]  = in_tag;
            pass_d[0] = '0;
            vld_d[0]  = in_valid;
        end
        for (int s = 1; s < L; s++) begin
            st_d[s]   = st_q[s-1];
            xx_d[s]   = xx_q[s-1];
            tag_d[s]  = tag_q[s-1];
            pass_d[s] = pass_q[s-1];
            vld_d[s]  = vld_q[s-1];
        end
    end

    // Pipeline stage registers; sideband rides alongside the state words.
    always_ff @(posedge clk) begin
        for (int s = 0; s < L; s++) begin
            st_q[s]  <= quarter_step(st_d[s], 3'(s % 8));
            xx_q[s]  <= xx_d[s];
            tag_q[s] <= tag_d[s];
            if (!reset_n) begin
                vld_q[s]  <= 1'b0;
                pass_q[s] <= '0;
            end else begin
                vld_q[s]  <= vld_d[s];
                pass_q[s] <= pass_d[s];
            end
        end
    end

    // Occupancy next-state: accept and completion in the same cycle cancel out.
    always_comb begin
        occ_d = occ_q;
        case ({accept_s, out_valid_q})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Final feed-forward add and output registers; data outputs hold between pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_bo_q    <= 512'd0;
            out_addr_q  <= '0;
            occ_q       <= '0;
        end else begin
            out_valid_q <= done_s;
            occ_q       <= occ_d;
            if (done_s) begin
                out_tag_q  <= tag_q[L-1];
                out_bo_q   <= sum_s;
                out_addr_q <= sum_s[ADDR_W-1:0];
            end else begin
                out_tag_q  <= out_tag_q;
                out_bo_q   <= out_bo_q;
                out_addr_q <= out_addr_q;
            end
        end
    end

    assign in_ready  = ready_s;
    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_bo    = out_bo_q;
    assign out_addr  = out_addr_q;
    assign occupancy = occ_q;
    assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_salsa_pipe_mt.sv
// Directed bench for salsa_pipe_mt: default config (DR=1) plus a DR=4 instance for streaming.
module tb_salsa_pipe_mt;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready, out_valid, busy;
    logic [3:0]   in_tag, out_tag;
    logic [511:0] in_b, in_bx, out_bo;
    logic [9:0]   out_addr;
    logic [3:0]   occupancy;
    logic         b_in_valid, b_in_ready, b_out_valid, b_busy;
    logic [3:0]   b_in_tag, b_out_tag;
    logic [511:0] b_in_b, b_in_bx, b_out_bo;
    logic [9:0]   b_out_addr;
    logic [5:0]   b_occupancy;

    always #5 clk = ~clk;

    salsa_pipe_mt dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_b(in_b), .in_bx(in_bx), .out_valid(out_valid), .out_tag(out_tag), .out_bo(out_bo),
        .out_addr(out_addr), .occupancy(occupancy), .busy(busy));

    salsa_pipe_mt #(.ROUNDS(8), .DR(4), .TAG_W(4), .ADDR_W(10)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_tag(b_in_tag),
        .in_b(b_in_b), .in_bx(b_in_bx), .out_valid(b_out_valid), .out_tag(b_out_tag), .out_bo(b_out_bo),
        .out_addr(b_out_addr), .occupancy(b_occupancy), .busy(b_busy));

    typedef struct { logic [3:0] tag; logic [511:0] bo; logic [9:0] addr; int cyc; } out_rec_t;
    typedef struct { logic [3:0] tag; logic [511:0] b; logic [511:0] bx; logic [511:0] exp_bo; logic [9:0] exp_addr; } vec_t;

    int       cyc = 0;
    int       n_tests = 0;
    int       n_fail = 0;
    int       acc_a[$];
    int       acc_b[$];
    out_rec_t out_a[$];
    out_rec_t out_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record acceptances and completions of both instances away from the active edge.
    always @(negedge clk) begin
        if (in_valid && in_ready) acc_a.push_back(cyc);
        if (out_valid) out_a.push_back('{out_tag, out_bo, out_addr, cyc});
        if (b_in_valid && b_in_ready) acc_b.push_back(cyc);
        if (b_out_valid) out_b.push_back('{b_out_tag, b_out_bo, b_out_addr, cyc});
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference Salsa20/8 core in the usual C form, including the feed-forward add.
    function automatic logic [511:0] salsa_ref(input logic [511:0] inp);
        logic [31:0]  x [16];
        logic [31:0]  z [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            x[i] = inp[32*i +: 32];
            z[i] = x[i];
        end
        for (int rd = 0; rd < 8; rd += 2) begin
            x[4]  ^= rl(x[0] + x[12], 7);   x[8]  ^= rl(x[4] + x[0], 9);
            x[12] ^= rl(x[8] + x[4], 13);   x[0]  ^= rl(x[12] + x[8], 18);
            x[9]  ^= rl(x[5] + x[1], 7);    x[13] ^= rl(x[9] + x[5], 9);
            x[1]  ^= rl(x[13] + x[9], 13);  x[5]  ^= rl(x[1] + x[13], 18);
            x[14] ^= rl(x[10] + x[6], 7);   x[2]  ^= rl(x[14] + x[10], 9);
            x[6]  ^= rl(x[2] + x[14], 13);  x[10] ^= rl(x[6] + x[2], 18);
            x[3]  ^= rl(x[15] + x[11], 7);  x[7]  ^= rl(x[3] + x[15], 9);
            x[11] ^= rl(x[7] + x[3], 13);   x[15] ^= rl(x[11] + x[7], 18);
            x[1]  ^= rl(x[0] + x[3], 7);    x[2]  ^= rl(x[1] + x[0], 9);
            x[3]  ^= rl(x[2] + x[1], 13);   x[0]  ^= rl(x[3] + x[2], 18);
            x[6]  ^= rl(x[5] + x[4], 7);    x[7]  ^= rl(x[6] + x[5], 9);
            x[4]  ^= rl(x[7] + x[6], 13);   x[5]  ^= rl(x[4] + x[7], 18);
            x[11] ^= rl(x[10] + x[9], 7);   x[8]  ^= rl(x[11] + x[10], 9);
            x[9]  ^= rl(x[8] + x[11], 13);  x[10] ^= rl(x[9] + x[8], 18);
            x[12] ^= rl(x[15] + x[14], 7);  x[13] ^= rl(x[12] + x[15], 9);
            x[14] ^= rl(x[13] + x[12], 13); x[15] ^= rl(x[14] + x[13], 18);
        end
        r = 512'd0;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + z[i];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        r = 512'd0;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int which, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (((which == 0) ? out_a.size() : out_b.size()) >= target) break;
            @(negedge clk);
        end
        chk_int($sformatf("output count dut%0d", which), (which == 0) ? out_a.size() : out_b.size(), target);
    endtask

    logic [511:0] kat_in, kat_out, rb, rbx, tmp, alt_b;
    logic [511:0] sat_b [12];
    logic [511:0] sat_bx [12];
    logic [511:0] sb [40];
    logic [511:0] sbx [40];
    vec_t         vecs [5];
    logic         rdy [200];
    int           a0, o0, c0, k, cnt, occ_max;
    logic         acc;

    initial begin
        kat_in  = {32'h5ec2b8b8, 32'h8dc6ebed, 32'h2948c709, 32'h291d0276,
                   32'h32aac55a, 32'h4b1e1214, 32'h853d9bdf, 32'h19f324ee,
                   32'h1d3bcd6d, 32'h1146f80d, 32'hb5c1618c, 32'h5b55eeba,
                   32'h268f7141, 32'he640a97c, 32'h86c93e4f, 32'h219a877e};
        kat_out = {32'h818f61c7, 32'h3d67ad24, 32'h5c74912c, 32'h10cc24e4,
                   32'hba966da0, 32'hb7c56bfe, 32'hbce6c9e3, 32'h683139b4,
                   32'h292f6896, 32'h631c7bfd, 32'h7d33fda2, 32'h81214b04,
                   32'h05ef0c02, 32'hcbca813b, 32'h99cc0866, 32'h9c851fa4};
        rb  = rand512();
        rbx = rand512();
        tmp = salsa_ref(rb ^ rbx);
        vecs[0] = '{4'd5,  512'd0, 512'd0, 512'd0,   10'd0};
        vecs[1] = '{4'd3,  kat_in, 512'd0, kat_out, 10'h3a4};
        vecs[2] = '{4'd9,  kat_in, kat_in, 512'd0,   10'd0};
        vecs[3] = '{4'd0,  512'd0, kat_in, kat_out, 10'h3a4};
        vecs[4] = '{4'd12, rb,     rbx,    tmp,     tmp[9:0]};

        reset_n = 1'b0;
        in_valid = 1'b0; in_tag = 4'd0; in_b = 512'd0; in_bx = 512'd0;
        b_in_valid = 1'b0; b_in_tag = 4'd0; b_in_b = 512'd0; b_in_bx = 512'd0;
        repeat (3) tick();
        @(negedge clk);
        chk_int("ready in reset", int'(in_ready), 0);
        chk_int("occupancy after reset", int'(occupancy), 0);
        chk_int("busy after reset", int'(busy), 0);
        chk("out_bo after reset", out_bo, 512'd0);
        chk_int("out_valid after reset", int'(out_valid), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // Table-driven single items: tag, data, address and latency
        for (int v = 0; v < 5; v++) begin
            a0 = acc_a.size();
            o0 = out_a.size();
            in_tag = vecs[v].tag; in_b = vecs[v].b; in_bx = vecs[v].bx; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk_int($sformatf("vec%0d accepted", v), acc_a.size(), a0 + 1);
            wait_out(0, o0 + 1, 100);
            if (out_a.size() > o0 && acc_a.size() > a0) begin
                chk_int($sformatf("vec%0d tag", v), int'(out_a[o0].tag), int'(vecs[v].tag));
                chk($sformatf("vec%0d bo", v), out_a[o0].bo, vecs[v].exp_bo);
                chk_int($sformatf("vec%0d addr", v), int'(out_a[o0].addr), int'(vecs[v].exp_addr));
                chk_int($sformatf("vec%0d latency", v), out_a[o0].cyc - acc_a[a0], 33);
            end
            repeat (3) tick();
        end

        // Reset with three items in flight
        o0 = out_a.size();
        for (int i = 1; i <= 3; i++) begin
            in_tag = 4'(i); in_b = rand512(); in_bx = 512'd0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk_int("occupancy before reset", int'(occupancy), 3);
        reset_n = 1'b0;
        @(negedge clk);
        chk_int("ready during reset", int'(in_ready), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_int("mid reset out_valid", int'(out_valid), 0);
        chk("mid reset out_bo", out_bo, 512'd0);
        chk_int("mid reset out_tag", int'(out_tag), 0);
        chk_int("mid reset out_addr", int'(out_addr), 0);
        chk_int("mid reset occupancy", int'(occupancy), 0);
        chk_int("mid reset busy", int'(busy), 0);
        repeat (50) tick();
        chk_int("no output after reset", out_a.size(), o0);

        // Saturation with a held-then-changed item under stall
        for (int i = 0; i < 12; i++) begin
            sat_b[i]  = rand512();
            sat_bx[i] = rand512();
        end
        alt_b = rand512();
        a0 = acc_a.size();
        o0 = out_a.size();
        c0 = cyc;
        k = 0;
        occ_max = 0;
        for (int t = 0; t < 200; t++) rdy[t] = 1'b0;
        for (int t = 0; t < 200 && k < 12; t++) begin
            in_valid = 1'b1;
            in_tag = 4'(k);
            in_b = (k == 8 && t < 20) ? alt_b : sat_b[k];
            in_bx = sat_bx[k];
            @(negedge clk);
            acc = in_ready;
            rdy[t] = in_ready;
            if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
            @(posedge clk); #1;
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk_int("saturation accepted", acc_a.size() - a0, 12);
        cnt = 0;
        for (int t = 8; t < 32; t++) cnt += int'(rdy[t]);
        chk_int("ready during stall window", cnt, 0);
        chk_int("ready reopens cycle 32", int'(rdy[32]), 1);
        if (acc_a.size() >= a0 + 12) begin
            for (int i = 0; i < 12; i++) begin
                chk_int($sformatf("sat accept cycle %0d", i), acc_a[a0 + i] - c0, (i < 8) ? i : i + 24);
            end
        end
        wait_out(0, o0 + 12, 200);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
            if (!busy) break;
        end
        chk_int("occupancy peak 8 or 9", int'(occ_max == 8 || occ_max == 9), 1);
        if (out_a.size() >= o0 + 12 && acc_a.size() >= a0 + 12) begin
            for (int i = 0; i < 12; i++) begin
                chk_int($sformatf("sat order %0d", i), int'(out_a[o0 + i].tag), i);
                chk($sformatf("sat bo %0d", i), out_a[o0 + i].bo, salsa_ref(sat_b[i] ^ sat_bx[i]));
                chk_int($sformatf("sat latency %0d", i), out_a[o0 + i].cyc - acc_a[a0 + i], 33);
            end
        end
        tick();
        chk_int("sat drained occupancy", int'(occupancy), 0);
        chk_int("sat drained busy", int'(busy), 0);

        // DR=4 instance: back-to-back stream, no recirculation
        for (int i = 0; i < 40; i++) begin
            sb[i]  = rand512();
            sbx[i] = rand512();
        end
        a0 = acc_b.size();
        o0 = out_b.size();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            b_in_valid = 1'b1; b_in_tag = 4'(i); b_in_b = sb[i]; b_in_bx = sbx[i];
            @(negedge clk);
            if (!b_in_ready) cnt++;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        chk_int("dr4 not-ready cycles", cnt, 0);
        chk_int("dr4 accepted", acc_b.size() - a0, 40);
        wait_out(1, o0 + 40, 200);
        if (out_b.size() >= o0 + 40 && acc_b.size() >= a0 + 40) begin
            for (int i = 0; i < 40; i++) begin
                tmp = salsa_ref(sb[i] ^ sbx[i]);
                chk_int($sformatf("dr4 tag %0d", i), int'(out_b[o0 + i].tag), i % 16);
                chk($sformatf("dr4 bo %0d", i), out_b[o0 + i].bo, tmp);
                chk_int($sformatf("dr4 addr %0d", i), int'(out_b[o0 + i].addr), int'(tmp[9:0]));
                chk_int($sformatf("dr4 latency %0d", i), out_b[o0 + i].cyc - acc_b[a0 + i], 33);
            end
        end
        repeat (2) tick();
        chk_int("dr4 drained occupancy", int'(b_occupancy), 0);
        chk_int("dr4 drained busy", int'(b_busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
